// File: rtl/fetch_prefetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding and
// the default {pc, instr} queue entry.
package fetch_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int unsigned FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO: power-of-two depth, synchronous flush, head entry
// presented combinationally.
module fetch_queue
  import fetch_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Flush wins over push and pop issued in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_head];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: runs sequential I-cache reads ahead of decode
// into a prefetch queue, with redirect flush and in-flight response discard.
//
// state   | meaning
// IDLE    | no request outstanding; waits for a free queue slot
// FETCH   | request to fetch_pc outstanding; response is pushed
// DISCARD | request to an old PC outstanding after redirect; response dropped
module fetch_prefetch
  import fetch_types::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h6000_0000,
  localparam int unsigned    CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_resp,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [CW-1:0]   out_count
);

  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_discard_addr;
  logic            r_imem_read;

  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ_next;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_unused_pc_lsb;
  entry_t          w_push_entry;
  entry_t          w_head;

  assign w_redirect_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign out_valid    = (w_count != '0);
  assign w_pop        = out_valid && out_ready && !redirect;
  assign w_push       = (r_state == FETCH) && imem_resp && !redirect;
  assign w_push_entry = '{pc: r_fetch_pc, instr: imem_rdata};
  assign w_occ_next   = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_fetch_pc     <= RESET_PC;
      r_discard_addr <= '0;
      r_imem_read    <= 1'b0;
    end else if (redirect) begin
      // A flushed queue always has room, so every redirect leads to a fetch.
      r_fetch_pc  <= w_redirect_pc;
      r_imem_read <= 1'b1;
      if ((r_state == FETCH || r_state == DISCARD) && !imem_resp) begin
        r_state <= DISCARD;
        if (r_state == FETCH) begin
          r_discard_addr <= r_fetch_pc;
        end
      end else begin
        r_state <= FETCH;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if ({1'b0, w_count} < DEPTH_C) begin
            r_state     <= FETCH;
            r_imem_read <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_resp) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_occ_next >= DEPTH_C) begin
              r_state     <= IDLE;
              r_imem_read <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            r_state <= FETCH;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_imem_read <= 1'b0;
        end
      endcase
    end
  end

  assign imem_read    = r_imem_read;
  assign imem_address = (r_state == DISCARD) ? r_discard_addr : r_fetch_pc;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_data(w_push_entry),
    .pop      (w_pop),
    .flush    (redirect),
    .count    (w_count),
    .head     (w_head)
  );

  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign out_count = w_count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: I-cache responder model plus an in-order
// scoreboard of delivered {pc, instr} pairs, and directed scenario checks.
module tb_fetch_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] BASE  = 32'h6000_0000;
  localparam logic [31:0] SALT  = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_read;
  logic [XLEN-1:0] imem_address;
  logic            imem_resp;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [CW-1:0]   out_count;

  fetch_prefetch #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_read   (imem_read),
    .imem_address(imem_address),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        exp_q [$];
  logic [31:0] req_log [$];
  int          pushes = 0;
  int          pops   = 0;
  logic        redirect_prev = 1'b0;

  logic        busy = 1'b0;
  logic        poisoned = 1'b0;
  logic [31:0] req_addr = '0;
  int          wait_cnt = 0;
  int          lat = 0;
  logic [31:0] slow_addr = '1;
  int          slow_lat = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // I-cache model: one request at a time, response after a per-address latency.
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        busy      = 1'b0;
        imem_resp = 1'b0;
      end else begin
        if (busy && redirect && !imem_resp) poisoned = 1'b1;
        if (imem_resp) begin
          busy      = 1'b0;
          imem_resp = 1'b0;
        end
        if (!busy && imem_read) begin
          busy     = 1'b1;
          poisoned = 1'b0;
          req_addr = imem_address;
          req_log.push_back(imem_address);
          wait_cnt = (imem_address == slow_addr) ? slow_lat : lat;
        end
        if (busy) begin
          if (wait_cnt == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = req_addr ^ SALT;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Scoreboard: occupancy, request stability, and in-order delivery.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      redirect_prev = 1'b0;
    end else begin
      chk("occupancy", 64'(out_count), 64'(exp_q.size()));
      if (redirect_prev) chk("valid_after_redirect", 64'(out_valid), 64'(0));
      if (busy) begin
        chk("addr_hold", 64'(imem_address), 64'(req_addr));
        chk("read_hold", 64'(imem_read), 64'(1));
      end
      if (redirect) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(out_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_instr", 64'(out_instr), 64'(e.instr));
            pops++;
          end
        end
        if (busy && imem_resp && !poisoned) begin
          exp_q.push_back('{pc: req_addr, instr: req_addr ^ SALT});
          pushes++;
        end
      end
      redirect_prev = redirect;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic ready, input int l, input logic [31:0] s_addr, input int s_lat);
    rst = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    out_ready = ready;
    lat       = l;
    slow_addr = s_addr;
    slow_lat  = s_lat;
    rst = 1'b1;
  endtask

  initial begin
    int n0;
    int p0;
    logic ok;

    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_read", 64'(imem_read), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(out_count), 64'(0));
    chk("rst_pc", 64'(out_pc), 64'(0));
    chk("rst_instr", 64'(out_instr), 64'(0));

    // Streaming with zero-latency cache and decode always ready.
    n0 = req_log.size();
    p0 = pops;
    out_ready = 1'b1; lat = 0;
    rst = 1'b1;
    tick();
    chk("t1_first_read", 64'(imem_read), 64'(1));
    chk("t1_first_addr", 64'(imem_address), 64'(BASE));
    tick();
    chk("t1_lat_valid", 64'(out_valid), 64'(1));
    chk("t1_lat_pc", 64'(out_pc), 64'(BASE));
    repeat (20) tick();
    chk("t1_req_cnt", 64'(req_log.size() - n0 >= 8), 64'(1));
    for (int k = 0; k < 8; k++) chk("t1_seq_addr", 64'(req_log[n0 + k]), 64'(BASE + 32'(4 * k)));
    chk("t1_delivered", 64'(pops - p0 >= 15), 64'(1));

    // Backpressure: queue fills, fetching stops, one pop admits one request.
    do_reset(1'b0, 1, '1, 0);
    n0 = req_log.size();
    p0 = pushes;
    repeat (16) tick();
    chk("t2_full_count", 64'(out_count), 64'(4));
    chk("t2_full_read", 64'(imem_read), 64'(0));
    chk("t2_full_pushes", 64'(pushes - p0), 64'(4));
    chk("t2_full_reqs", 64'(req_log.size() - n0), 64'(4));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_pop_count", 64'(out_count), 64'(3));
    repeat (6) tick();
    chk("t2_refill_reqs", 64'(req_log.size() - n0), 64'(5));
    chk("t2_refill_addr", 64'(req_log[n0 + 4]), 64'(BASE + 32'h10));
    chk("t2_refill_count", 64'(out_count), 64'(4));
    chk("t2_refill_read", 64'(imem_read), 64'(0));

    // Redirect while a slow request is outstanding.
    do_reset(1'b1, 0, BASE + 32'h8, 3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_read && imem_address == BASE + 32'h8) begin ok = 1'b1; break; end
    end
    chk("t3_wait_req", 64'(ok), 64'(1));
    redirect = 1'b1; redirect_pc = BASE + 32'h103;
    n0 = req_log.size();
    tick();
    redirect = 1'b0;
    chk("t3_disc_addr", 64'(imem_address), 64'(BASE + 32'h8));
    chk("t3_disc_read", 64'(imem_read), 64'(1));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t3_disc_valid", 64'(out_valid), 64'(0));
      if (req_log.size() > n0) begin ok = 1'b1; break; end
      tick();
    end
    chk("t3_wait_new", 64'(ok), 64'(1));
    if (ok) chk("t3_new_addr", 64'(req_log[n0]), 64'(BASE + 32'h100));
    tick();
    chk("t3_new_valid", 64'(out_valid), 64'(1));
    chk("t3_new_pc", 64'(out_pc), 64'(BASE + 32'h100));
    chk("t3_new_instr", 64'(out_instr), 64'((BASE + 32'h100) ^ SALT));

    // Redirect coinciding with a response and a pop.
    do_reset(1'b1, 0, '1, 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_resp && out_valid) begin ok = 1'b1; break; end
    end
    chk("t4_wait_busy", 64'(ok), 64'(1));
    redirect = 1'b1; redirect_pc = BASE + 32'h200;
    tick();
    redirect = 1'b0;
    chk("t4_count", 64'(out_count), 64'(0));
    chk("t4_valid", 64'(out_valid), 64'(0));
    chk("t4_read", 64'(imem_read), 64'(1));
    chk("t4_addr", 64'(imem_address), 64'(BASE + 32'h200));
    repeat (3) tick();

    // Two redirects inside one discard window; only the last PC is fetched.
    do_reset(1'b1, 0, BASE + 32'h8, 4);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_read && imem_address == BASE + 32'h8) begin ok = 1'b1; break; end
    end
    chk("t5_wait_req", 64'(ok), 64'(1));
    redirect = 1'b1; redirect_pc = BASE + 32'h300;
    tick();
    chk("t5_disc_addr", 64'(imem_address), 64'(BASE + 32'h8));
    redirect_pc = BASE + 32'h400;
    n0 = req_log.size();
    tick();
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_log.size() > n0) begin ok = 1'b1; break; end
      tick();
    end
    chk("t5_wait_new", 64'(ok), 64'(1));
    if (ok) chk("t5_new_addr", 64'(req_log[n0]), 64'(BASE + 32'h400));
    repeat (3) tick();

    // Asynchronous reset in the middle of a fetch with three entries queued.
    do_reset(1'b0, 1, '1, 0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_count == 3 && imem_read) begin ok = 1'b1; break; end
    end
    chk("t6_wait_fill", 64'(ok), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_read", 64'(imem_read), 64'(0));
    chk("t6_async_valid", 64'(out_valid), 64'(0));
    chk("t6_async_count", 64'(out_count), 64'(0));
    tick();
    tick();
    n0 = req_log.size();
    rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_log.size() > n0) begin ok = 1'b1; break; end
    end
    chk("t6_wait_restart", 64'(ok), 64'(1));
    if (ok) chk("t6_restart_addr", 64'(req_log[n0]), 64'(BASE));
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised instruction-fetch front end. It replaces the direct imem_read/imem_address/imem_rdata wiring of the single-issue core top.
- Sits between the I-cache port and the decode stage of the pipelined rv32i core.
- Runs sequential fetches ahead of decode into a DEPTH-entry prefetch queue and presents {pc, instr} pairs on a valid/ready interface.
- Supports a redirect from execute (branch/jump), which flushes the queue and safely discards an in-flight cache request.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- XLEN, 32, address/PC width
- RESET_PC, 32'h6000_0000, first fetch address after reset

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- imem_read  out  1  I-cache read request; held until imem_resp
- imem_address  out  XLEN  I-cache address; stable while imem_read=1 and no imem_resp
- imem_resp  in  1  I-cache response strobe, one cycle
- imem_rdata  in  32  instruction word, valid with imem_resp
- redirect  in  1  flush-and-refetch request from execute
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  32  head instruction word
- out_count  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Reset (rst=0, async) forces the following:
  - state=IDLE, fetch_pc=RESET_PC, count=0, head/tail pointers=0
  - imem_read=0, out_valid=0, out_count=0
  - out_pc and out_instr are don't-care while out_valid=0 (they reset to 0)
- Reset mid-request abandons the request; the I-cache shares the same reset.
- States: IDLE, FETCH, DISCARD.
- imem_read=1 exactly in FETCH and DISCARD. imem_address=fetch_pc in FETCH, and the latched old address in DISCARD.
- IDLE:
  - if count<DEPTH, go to FETCH next cycle.
  - the first request after reset release asserts imem_read in cycle 1.
- FETCH, with imem_resp=1 and no redirect:
  - push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps mod 2^XLEN).
  - stay in FETCH if occupancy after this cycle's push and pop is < DEPTH, else go to IDLE.
  - back-to-back requests are allowed; imem_read stays high with the new address next cycle.
- Issue rule: a request is only issued with count<DEPTH, and at most one is outstanding, so a response always has a free slot. No overflow is possible.
- Pushed entry latency: out_valid=1 the cycle after imem_resp.
- Pop occurs when out_valid && out_ready. out_pc and out_instr are combinational from the head entry.
- Simultaneous push and pop leave count unchanged.
- Redirect has the highest priority in any state:
  - count becomes 0, pointers reset, fetch_pc becomes {redirect_pc[XLEN-1:2], 2'b00}.
  - any pop in the same cycle is ignored.
- Redirect in FETCH without imem_resp the same cycle:
  - go to DISCARD, holding the old address and imem_read=1 until imem_resp.
  - the response data is dropped, then go to FETCH at the new PC.
- Redirect in FETCH with imem_resp the same cycle: the data is dropped and the next state is FETCH at the new PC.
- Redirect in DISCARD: update fetch_pc to the newest redirect_pc and remain in DISCARD (or leave it if imem_resp arrives the same cycle).
- Redirect in IDLE: the flush makes room, so the next state is FETCH.
- out_valid=0 in the cycle after any redirect.

Decomposition:
- Package fetch_types:
  - typedef enum fetch_state_t {IDLE, FETCH, DISCARD}
  - typedef struct fetch_entry_t {pc, instr}
- Sub-module fetch_queue: circular FIFO parametrised on DEPTH and entry type.
  - Ports: push, pop, flush (synchronous clear), count, head data; same async active-low rst.
  - fetch_prefetch holds the FSM, fetch_pc, and the discard logic.

Test Plan:
- Reset release, cache responds 1 cycle after each request, out_ready=1 -> imem_address sequence 0x60000000, 0x60000004, 0x60000008…; out_pc follows with 1-cycle lag; every instruction is delivered exactly once.
- out_ready=0, DEPTH=4 -> exactly 4 responses are accepted, out_count=4, imem_read drops to 0. Raising out_ready for one cycle -> out_count=3 and exactly one new request at 0x60000010.
- Redirect to 0x60000103 while a request to 0x60000008 is pending (resp 3 cycles later) -> imem_address holds 0x60000008 until resp; that data never appears at the output; the next request is 0x60000100; out_valid=0 until its response.
- Redirect to 0x60000200 in the same cycle as imem_resp and a pop -> response dropped, out_count=0 next cycle, next request 0x60000200.
- Two redirects (0x60000300, then 0x60000400) during one DISCARD -> only 0x60000400 is fetched afterwards.
- Assert rst=0 asynchronously mid-FETCH with the queue holding 3 entries -> imem_read, out_valid and out_count go to 0 immediately without a clock edge; after release, fetching restarts at 0x60000000.
